// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory request bus plus the single-ported RAM bus it is served on.
// The arbiter takes the slave modport; caches and RAM model take the master side.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache fetches and dcache reads/writes onto one RAM port, with a
// data-streak limit so a busy dcache cannot starve instruction fetch.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input logic               CLK,
  input logic               nRST,
  cache_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t            state;
  logic [SW-1:0]     streak;
  logic [TW-1:0]     tmo;
  logic              err_q;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic [DATA_W-1:0] iload_n, dload_n;

  logic d_req, d_live, i_live, live, rs_access, rs_error, done, fail;

  // "live" means the granted request is still asserted; a dropped request
  // aborts silently and never counts as a completion.
  assign d_req     = bus.dREN | bus.dWEN;
  assign d_live    = (state == DSERV) && d_req;
  assign i_live    = (state == ISERV) && bus.iREN;
  assign live      = d_live | i_live;
  assign rs_access = (bus.ramstate == RAM_ACCESS);
  assign rs_error  = (bus.ramstate == RAM_ERROR);
  assign done      = live && (rs_access || rs_error || (tmo == TW'(TIMEOUT - 1)));
  assign fail      = done && !rs_access;

  // NOTE: every output gets a default before the conditionals, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    bus.ramREN   = i_live | (d_live & ~bus.dWEN);
    bus.ramWEN   = d_live & bus.dWEN;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {DATA_W{1'b0}};
    if (d_live) begin
      bus.ramaddr = bus.daddr;
      if (bus.dWEN) bus.ramstore = bus.dstore;
    end else if (i_live) begin
      bus.ramaddr = bus.iaddr;
    end

    bus.iwait = !(i_live && done);
    bus.dwait = !(d_live && done);

    // Load data is presented in the completion cycle and held until the next one.
    iload_n = iload_q;
    dload_n = dload_q;
    if (i_live && done) iload_n = fail ? {DATA_W{1'b0}} : bus.ramload;
    if (d_live && done) begin
      if (fail)           dload_n = {DATA_W{1'b0}};
      else if (!bus.dWEN) dload_n = bus.ramload;
    end
  end

  assign bus.iload = iload_n;
  assign bus.dload = dload_n;
  assign bus.err   = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // NOTE: the held load words are plain registers, not a RAM array, so they
      // reset to zero like the rest of the state.
      state   <= IDLE;
      streak  <= '0;
      tmo     <= '0;
      err_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      iload_q <= iload_n;
      dload_q <= dload_n;
      if (fail || (d_live && bus.dREN && bus.dWEN)) err_q <= 1'b1;

      case (state)
        IDLE: begin
          tmo <= '0;
          if (d_req && !(bus.iREN && (streak == SW'(MAX_DSTREAK)))) begin
            state  <= DSERV;
            streak <= bus.iREN ? streak + 1'b1 : '0;
          end else if (bus.iREN) begin
            state  <= ISERV;
            streak <= '0;
          end else begin
            streak <= '0;
          end
        end
        default: begin
          tmo <= tmo + 1'b1;
          if (!live || done) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a small RAM model plus per-feature tasks
// with hand-computed expectations, built with TIMEOUT = 8.
module tb_cache_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [0:255];

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // RAM model: word 0x40 preloaded while in reset, writes land on ACCESS.
  always @(posedge CLK) begin
    if (!nRST) mem[16] <= 32'h2001000A;
    else if (bus.ramWEN && bus.ramstate == ACCESS) mem[bus.ramaddr[9:2]] <= bus.ramstore;
  end
  assign bus.ramload = bus.ramREN ? mem[bus.ramaddr[9:2]] : 32'h0;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    sample();
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL reset_iwait: got %h expected 1", bus.iwait); end
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL reset_dwait: got %h expected 1", bus.dwait); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN: got %h expected 0", bus.ramWEN); end
    n_checks++; if (bus.ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr: got %h expected 0", bus.ramaddr); end
    n_checks++; if (bus.ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore: got %h expected 0", bus.ramstore); end
    n_checks++; if (bus.iload !== 32'h0) begin n_fail++; $display("FAIL reset_iload: got %h expected 0", bus.iload); end
    n_checks++; if (bus.dload !== 32'h0) begin n_fail++; $display("FAIL reset_dload: got %h expected 0", bus.dload); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", bus.err); end
    nRST = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    sample();
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL rd_c1_iwait: got %h expected 1", bus.iwait); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rd_c1_ramREN: got %h expected 0", bus.ramREN); end
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.iwait !== 1'b0) begin n_fail++; $display("FAIL rd_c2_iwait: got %h expected 0", bus.iwait); end
    n_checks++; if (bus.iload !== 32'h2001000A) begin n_fail++; $display("FAIL rd_c2_iload: got %h expected 2001000a", bus.iload); end
    n_checks++; if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL rd_c2_ramREN: got %h expected 1", bus.ramREN); end
    n_checks++; if (bus.ramaddr !== 32'h40) begin n_fail++; $display("FAIL rd_c2_ramaddr: got %h expected 40", bus.ramaddr); end
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL rd_c2_dwait: got %h expected 1", bus.dwait); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL rd_c3_iwait: got %h expected 1", bus.iwait); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rd_c3_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.iload !== 32'h2001000A) begin n_fail++; $display("FAIL rd_c3_iload_held: got %h expected 2001000a", bus.iload); end
    next_cycle();
  endtask

  task automatic test_write_readback();
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hCAFEF00D; bus.ramstate = FREE;
    sample();
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL wr_c1_dwait: got %h expected 1", bus.dwait); end
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.ramWEN !== 1'b1) begin n_fail++; $display("FAIL wr_ramWEN: got %h expected 1", bus.ramWEN); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL wr_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.ramstore !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wr_ramstore: got %h expected cafef00d", bus.ramstore); end
    n_checks++; if (bus.ramaddr !== 32'h100) begin n_fail++; $display("FAIL wr_ramaddr: got %h expected 100", bus.ramaddr); end
    n_checks++; if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL wr_dwait: got %h expected 0", bus.dwait); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL wr_c3_dwait: got %h expected 1", bus.dwait); end
    n_checks++; if (bus.ramWEN !== 1'b0) begin n_fail++; $display("FAIL wr_c3_ramWEN: got %h expected 0", bus.ramWEN); end
    next_cycle();
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL rb_dwait: got %h expected 0", bus.dwait); end
    n_checks++; if (bus.dload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rb_dload: got %h expected cafef00d", bus.dload); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.dload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rb_dload_held: got %h expected cafef00d", bus.dload); end
    next_cycle();
  endtask

  task automatic test_latency();
    bus.dREN = 1'b1; bus.daddr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      bus.ramstate = (c == 5) ? ACCESS : BUSY;
      if (c == 6) idle_inputs();
      sample();
      n_checks++; if (bus.dwait !== (c != 5)) begin n_fail++; $display("FAIL lat_dwait_c%0d: got %h expected %h", c, bus.dwait, (c != 5)); end
      if (c == 5) begin
        n_checks++; if (bus.dload !== 32'h2001000A) begin n_fail++; $display("FAIL lat_dload: got %h expected 2001000a", bus.dload); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_i, exp_d;
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = ACCESS;
    for (int c = 1; c <= 20; c++) begin
      sample();
      exp_i = (c % 2 == 0) && (((c / 2) - 1) % 5 == 4);
      exp_d = (c % 2 == 0) && !exp_i;
      n_checks++; if (bus.iwait !== !exp_i) begin n_fail++; $display("FAIL b2b_iwait_c%0d: got %h expected %h", c, bus.iwait, !exp_i); end
      n_checks++; if (bus.dwait !== !exp_d) begin n_fail++; $display("FAIL b2b_dwait_c%0d: got %h expected %h", c, bus.dwait, !exp_d); end
      if (exp_i) begin
        n_checks++; if (bus.iload !== 32'h2001000A) begin n_fail++; $display("FAIL b2b_iload_c%0d: got %h expected 2001000a", c, bus.iload); end
      end
      if (exp_d) begin
        n_checks++; if (bus.dload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_dload_c%0d: got %h expected cafef00d", c, bus.dload); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_abort();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    next_cycle();
    sample();
    n_checks++; if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_busy_ramREN: got %h expected 1", bus.ramREN); end
    next_cycle();
    bus.iREN = 1'b0;
    sample();
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_drop_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL abort_drop_iwait: got %h expected 1", bus.iwait); end
    next_cycle();
    bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL abort_idle_dwait: got %h expected 1", bus.dwait); end
    next_cycle();
    sample();
    n_checks++; if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL abort_regrant_dwait: got %h expected 0", bus.dwait); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %h expected 0", bus.err); end
    next_cycle();
  endtask

  task automatic test_dual();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678; bus.ramstate = FREE;
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.ramWEN !== 1'b1) begin n_fail++; $display("FAIL dual_ramWEN: got %h expected 1", bus.ramWEN); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL dual_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.ramstore !== 32'h12345678) begin n_fail++; $display("FAIL dual_ramstore: got %h expected 12345678", bus.ramstore); end
    n_checks++; if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL dual_dwait: got %h expected 0", bus.dwait); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL dual_err_before: got %h expected 0", bus.err); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL dual_err_after: got %h expected 1", bus.err); end
    next_cycle();
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.dload !== 32'h12345678) begin n_fail++; $display("FAIL dual_readback: got %h expected 12345678", bus.dload); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL dual_err_sticky: got %h expected 1", bus.err); end
    next_cycle();
  endtask

  task automatic test_ram_error();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.iload !== 32'h2001000A) begin n_fail++; $display("FAIL rerr_first_iload: got %h expected 2001000a", bus.iload); end
    next_cycle();
    bus.ramstate = FREE;
    sample();
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL rerr_turnaround_iwait: got %h expected 1", bus.iwait); end
    next_cycle();
    bus.ramstate = ERROR;
    sample();
    n_checks++; if (bus.iwait !== 1'b0) begin n_fail++; $display("FAIL rerr_iwait: got %h expected 0", bus.iwait); end
    n_checks++; if (bus.iload !== 32'h0) begin n_fail++; $display("FAIL rerr_iload: got %h expected 0", bus.iload); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rerr_err_before: got %h expected 0", bus.err); end
    next_cycle();
    idle_inputs();
    sample();
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL rerr_err_after: got %h expected 1", bus.err); end
    n_checks++; if (bus.iload !== 32'h0) begin n_fail++; $display("FAIL rerr_iload_held: got %h expected 0", bus.iload); end
    next_cycle();
  endtask

  task automatic test_timeout();
    bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = FREE;
    next_cycle();
    bus.ramstate = ACCESS;
    sample();
    n_checks++; if (bus.dload !== 32'h2001000A) begin n_fail++; $display("FAIL tmo_pre_dload: got %h expected 2001000a", bus.dload); end
    next_cycle();
    // cycle 3 is the turnaround IDLE, service cycles 4..11; the 8th is cycle 11
    for (int c = 3; c <= 13; c++) begin
      bus.ramstate = BUSY;
      if (c == 12) bus.dREN = 1'b0;
      sample();
      n_checks++; if (bus.dwait !== (c != 11)) begin n_fail++; $display("FAIL tmo_dwait_c%0d: got %h expected %h", c, bus.dwait, (c != 11)); end
      if (c == 11) begin
        n_checks++; if (bus.dload !== 32'h0) begin n_fail++; $display("FAIL tmo_dload: got %h expected 0", bus.dload); end
      end
      n_checks++; if (bus.err !== (c >= 12)) begin n_fail++; $display("FAIL tmo_err_c%0d: got %h expected %h", c, bus.err, (c >= 12)); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = BUSY;
    next_cycle();
    sample();
    n_checks++; if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL rmid_serv_ramREN: got %h expected 1", bus.ramREN); end
    next_cycle();
    nRST = 1'b0;
    next_cycle();
    sample();
    n_checks++; if (bus.iwait !== 1'b1) begin n_fail++; $display("FAIL rmid_iwait: got %h expected 1", bus.iwait); end
    n_checks++; if (bus.dwait !== 1'b1) begin n_fail++; $display("FAIL rmid_dwait: got %h expected 1", bus.dwait); end
    n_checks++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rmid_ramREN: got %h expected 0", bus.ramREN); end
    n_checks++; if (bus.ramWEN !== 1'b0) begin n_fail++; $display("FAIL rmid_ramWEN: got %h expected 0", bus.ramWEN); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %h expected 0", bus.err); end
    nRST = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.dstore = 32'h0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_readback();
    test_latency();
    test_back_to_back();
    test_abort();
    test_dual();
    apply_reset();
    test_ram_error();
    apply_reset();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
